// File: rtl/uart_spi_cmd_sequencer.sv
// ASCII command-frame sequencer between the UART and the SPI master.
// Accepts "{op:AAA:DDDDD" frames one byte at a time, issues one SPI
// register access, then answers with "K\r\n", "<5 hex>\r\n" or "E\r\n".
module uart_spi_cmd_sequencer #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 20,
    parameter int unsigned BYTE_TIMEOUT = 200000,
    parameter int unsigned SPI_TIMEOUT  = 100000
) (
    input  logic              i_clk_sys,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_spi_start,
    output logic              o_spi_rw,
    output logic [ADDR_W-1:0] o_spi_addr,
    output logic [DATA_W-1:0] o_spi_wdata,
    input  logic              i_spi_busy,
    input  logic              i_spi_done,
    input  logic [DATA_W-1:0] i_spi_rdata,
    output logic              o_busy
);

    localparam int unsigned ADIG    = ADDR_W / 4;
    localparam int unsigned DDIG    = DATA_W / 4;
    localparam int unsigned TMO_MAX = (BYTE_TIMEOUT > SPI_TIMEOUT) ? BYTE_TIMEOUT : SPI_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMO_MAX + 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_OP    = 4'd1;
    localparam logic [3:0] S_COL1  = 4'd2;
    localparam logic [3:0] S_ADDR  = 4'd3;
    localparam logic [3:0] S_COL2  = 4'd4;
    localparam logic [3:0] S_DATA  = 4'd5;
    localparam logic [3:0] S_ISSUE = 4'd6;
    localparam logic [3:0] S_WAIT  = 4'd7;
    localparam logic [3:0] S_RESP  = 4'd8;
    localparam logic [3:0] S_ERR   = 4'd9;

    logic [3:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [2:0]        tx_idx_q, tx_idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              spi_start_q, spi_start_d;

    logic              hex_ok;
    logic [3:0]        hex_nib;
    logic [3:0]        rd_nib;
    logic [7:0]        resp_byte;
    logic              resp_last;

    // {valid, nibble} for an ASCII hex digit in either case
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= "0" && c <= "9")
            return {1'b1, c[3:0]};
        else if ((c >= "A" && c <= "F") || (c >= "a" && c <= "f"))
            return {1'b1, 4'(c[3:0] + 4'd9)};
        else
            return 5'b0;
    endfunction

    // Uppercase ASCII for a nibble
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    // Pick the read-data nibble for the current response position, MSB first
    always_comb begin
        rd_nib = '0;
        for (int unsigned i = 0; i < DDIG; i++) begin
            if (tx_idx_q == 3'(i))
                rd_nib = rdata_q[4*(DDIG-1-i) +: 4];
        end
    end

    // Byte to present for the current response position
    always_comb begin
        resp_byte = '0;
        resp_last = 1'b0;
        if (state_q == S_RESP && rw_q) begin
            if (tx_idx_q < 3'(DDIG)) begin
                resp_byte = hex_ascii(rd_nib);
            end else if (tx_idx_q == 3'(DDIG)) begin
                resp_byte = 8'h0D;
            end else begin
                resp_byte = 8'h0A;
                resp_last = 1'b1;
            end
        end else begin
            case (tx_idx_q)
                3'd0:    resp_byte = (state_q == S_ERR) ? "E" : "K";
                3'd1:    resp_byte = 8'h0D;
                default: begin
                    resp_byte = 8'h0A;
                    resp_last = 1'b1;
                end
            endcase
        end
    end

    // Frame parser, SPI issue/wait and response sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        timer_d     = timer_q;
        tx_idx_d    = tx_idx_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        spi_start_d = 1'b0;
        {hex_ok, hex_nib} = hex_decode(i_rx_data);

        case (state_q)
            S_IDLE: begin
                timer_d  = '0;
                tx_idx_d = '0;
                if (i_rx_valid && i_rx_data == "{") begin
                    state_d = S_OP;
                    addr_d  = '0;
                    wdata_d = '0;
                    cnt_d   = '0;
                end
            end

            S_OP, S_COL1, S_ADDR, S_COL2, S_DATA: begin
                if (i_rx_valid) begin
                    timer_d = '0;
                    if (i_rx_data == "{") begin
                        state_d = S_OP;
                        addr_d  = '0;
                        wdata_d = '0;
                        cnt_d   = '0;
                    end else begin
                        // Anything not explicitly accepted below is an error
                        state_d = S_ERR;
                        case (state_q)
                            S_OP: begin
                                if (i_rx_data == "W" || i_rx_data == "w") begin
                                    rw_d    = 1'b0;
                                    state_d = S_COL1;
                                end else if (i_rx_data == "R" || i_rx_data == "r") begin
                                    rw_d    = 1'b1;
                                    state_d = S_COL1;
                                end
                            end
                            S_COL1: begin
                                if (i_rx_data == ":") begin
                                    state_d = S_ADDR;
                                    cnt_d   = '0;
                                end
                            end
                            S_ADDR: begin
                                if (hex_ok) begin
                                    addr_d = {addr_q[ADDR_W-5:0], hex_nib};
                                    if (cnt_q == 3'(ADIG - 1)) begin
                                        state_d = S_COL2;
                                    end else begin
                                        state_d = S_ADDR;
                                        cnt_d   = cnt_q + 1'b1;
                                    end
                                end
                            end
                            S_COL2: begin
                                if (i_rx_data == ":") begin
                                    state_d = S_DATA;
                                    cnt_d   = '0;
                                end
                            end
                            S_DATA: begin
                                if (hex_ok) begin
                                    wdata_d = {wdata_q[DATA_W-5:0], hex_nib};
                                    if (cnt_q == 3'(DDIG - 1)) begin
                                        state_d = S_ISSUE;
                                    end else begin
                                        state_d = S_DATA;
                                        cnt_d   = cnt_q + 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (timer_q == TMR_W'(BYTE_TIMEOUT)) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_ISSUE: begin
                if (!i_spi_busy) begin
                    spi_start_d = 1'b1;
                    timer_d     = '0;
                    state_d     = S_WAIT;
                end
            end

            S_WAIT: begin
                if (i_spi_done) begin
                    rdata_d  = i_spi_rdata;
                    tx_idx_d = '0;
                    state_d  = S_RESP;
                end else if (timer_q == TMR_W'(SPI_TIMEOUT)) begin
                    tx_idx_d = '0;
                    state_d  = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_RESP, S_ERR: begin
                // Present a byte, hold it until accepted, then idle one cycle
                if (tx_valid_q) begin
                    if (i_tx_ready) begin
                        tx_valid_d = 1'b0;
                        if (resp_last)
                            state_d = S_IDLE;
                        else
                            tx_idx_d = tx_idx_q + 1'b1;
                    end
                end else begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = resp_byte;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            timer_q     <= '0;
            tx_idx_q    <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            spi_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            timer_q     <= timer_d;
            tx_idx_q    <= tx_idx_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            spi_start_q <= spi_start_d;
        end
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_spi_start = spi_start_q;
    assign o_spi_rw    = rw_q;
    assign o_spi_addr  = addr_q;
    assign o_spi_wdata = wdata_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_spi_cmd_sequencer.sv
// Directed bench for uart_spi_cmd_sequencer: table of frames with expected
// SPI access and UART response, plus hand-written timing corner cases.
module tb_uart_spi_cmd_sequencer;

    localparam int unsigned BT = 400;
    localparam int unsigned ST = 300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        spi_start;
    logic        spi_rw;
    logic [11:0] spi_addr;
    logic [19:0] spi_wdata;
    logic        spi_busy;
    logic        spi_done;
    logic [19:0] spi_rdata;
    logic        busy;

    uart_spi_cmd_sequencer #(
        .ADDR_W      (12),
        .DATA_W      (20),
        .BYTE_TIMEOUT(BT),
        .SPI_TIMEOUT (ST)
    ) dut (
        .i_clk_sys  (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_spi_start(spi_start),
        .o_spi_rw   (spi_rw),
        .o_spi_addr (spi_addr),
        .o_spi_wdata(spi_wdata),
        .i_spi_busy (spi_busy),
        .i_spi_done (spi_done),
        .i_spi_rdata(spi_rdata),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       frame;
        logic        rw;
        logic [11:0] addr;
        logic [19:0] wdata;
        logic [19:0] rdata;
        string       resp;
        int          starts;
    } vec_t;

    vec_t        vq[$];
    int          nvec = 0;
    int          nmis = 0;

    // SPI responder state (written only by the responder)
    int          start_cnt = 0;
    logic        last_rw = 1'b0;
    logic [11:0] last_addr = '0;
    logic [19:0] last_wdata = '0;
    // responder controls (written only by the main sequence)
    logic        spi_hang = 1'b0;
    logic [19:0] spi_rval = '0;

    // TX monitor state (written only by the monitor)
    logic [7:0]  txq[$];
    int          stab_err = 0;

    int          tx_base = 0;
    int          st_base = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // SPI master model: done 5 cycles after start unless told to hang
    initial begin
        int delay;
        delay = 0;
        spi_done = 1'b0;
        spi_rdata = '0;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (spi_start) begin
                start_cnt++;
                last_rw    = spi_rw;
                last_addr  = spi_addr;
                last_wdata = spi_wdata;
                delay = spi_hang ? 0 : 5;
            end else if (delay > 0) begin
                delay--;
                if (delay == 0) begin
                    spi_done  = 1'b1;
                    spi_rdata = spi_rval;
                end
            end
        end
    end

    // UART TX monitor: logs accepted bytes and checks hold while not ready
    initial begin
        logic       hold_prev;
        logic [7:0] hold_data;
        hold_prev = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (hold_prev && (!tx_valid || tx_data != hold_data))
                stab_err++;
            hold_prev = tx_valid && !tx_ready;
            hold_data = tx_data;
            if (tx_valid && tx_ready)
                txq.push_back(tx_data);
        end
    end

    function automatic string vis(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0D)      r = {r, "\\r"};
            else if (s[i] == 8'h0A) r = {r, "\\n"};
            else                    r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    function automatic string tx_str();
        string r;
        r = "";
        for (int i = tx_base; i < txq.size(); i++)
            r = $sformatf("%s%c", r, txq[i]);
        return r;
    endfunction

    task automatic chk_str(input string name, input string got, input string exp);
        nvec++;
        if (got != exp) begin
            nmis++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, vis(got), vis(exp));
        end
    endtask

    task automatic chk_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    task automatic mark();
        tx_base = txq.size();
        st_base = start_cnt;
    endtask

    task automatic wait_tx(input string name, input int n, input int budget, output int elapsed);
        elapsed = 0;
        while ((txq.size() - tx_base) < n && elapsed < budget) begin
            @(negedge clk);
            elapsed++;
        end
        if ((txq.size() - tx_base) < n) begin
            nvec++;
            nmis++;
            $display("FAIL %s_tx_timeout: got %0d bytes expected %0d", name, txq.size() - tx_base, n);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic add_vec(input string f, input logic rw, input logic [11:0] a,
                           input logic [19:0] wd, input logic [19:0] rd,
                           input string resp, input int starts);
        vec_t v;
        v.frame = f; v.rw = rw; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.resp = resp; v.starts = starts;
        vq.push_back(v);
    endtask

    initial begin
        int el;
        string kresp;
        string eresp;
        kresp = "K\015\012";
        eresp = "E\015\012";

        add_vec("{W:3CD:1aAfF",       1'b0, 12'h3CD, 20'h1AAFF, 20'h00000, kresp, 1);
        add_vec("{r:0A5:00000}",      1'b1, 12'h0A5, 20'h00000, 20'hABCDE, "ABCDE\015\012", 1);
        add_vec("{W:3G",              1'b0, 12'h000, 20'h00000, 20'h00000, eresp, 0);
        add_vec("{w:fff:00001",       1'b0, 12'hFFF, 20'h00001, 20'h00000, kresp, 1);
        add_vec("{W:12{R:456:00000",  1'b1, 12'h456, 20'h00000, 20'h01234, "01234\015\012", 1);
        add_vec("{X",                 1'b0, 12'h000, 20'h00000, 20'h00000, eresp, 0);
        add_vec("{R:1b2:FFFFF",       1'b1, 12'h1B2, 20'hFFFFF, 20'h00F0A, "00F0A\015\012", 1);
        add_vec("xy}{W:000:98765",    1'b0, 12'h000, 20'h98765, 20'h00000, kresp, 1);
        add_vec("{W:12:",             1'b0, 12'h000, 20'h00000, 20'h00000, eresp, 0);
        add_vec("{W;",                1'b0, 12'h000, 20'h00000, 20'h00000, eresp, 0);

        rst_n    = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        spi_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("reset_outputs",
                {20'h0, tx_valid, spi_start, spi_rw, busy, tx_data, spi_addr, spi_wdata},
                64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            mark();
            spi_rval = vq[i].rdata;
            send_str(vq[i].frame);
            wait_tx($sformatf("v%0d", i), vq[i].resp.len(), 200, el);
            chk_str($sformatf("v%0d_resp", i), tx_str(), vq[i].resp);
            chk_val($sformatf("v%0d_starts", i), 64'(start_cnt - st_base), 64'(vq[i].starts));
            if (vq[i].starts > 0)
                chk_val($sformatf("v%0d_rw_addr_wdata", i),
                        {31'h0, last_rw, last_addr, last_wdata},
                        {31'h0, vq[i].rw, vq[i].addr, vq[i].wdata});
            chk_val($sformatf("v%0d_idle", i), 64'(busy), 64'h0);
        end

        // Busy master holds off the issue for 500 cycles
        mark();
        spi_busy = 1'b1;
        send_str("{W:001:00002");
        repeat (500) @(negedge clk);
        chk_val("busy_no_start", 64'(start_cnt - st_base), 64'h0);
        chk_val("busy_o_busy", 64'(busy), 64'h1);
        spi_busy = 1'b0;
        wait_tx("busy", 3, 100, el);
        chk_str("busy_resp", tx_str(), kresp);
        chk_val("busy_start", {31'h0, last_rw, last_addr, last_wdata}, {31'h0, 1'b0, 12'h001, 20'h00002});

        // SPI master never completes
        mark();
        spi_hang = 1'b1;
        send_str("{R:010:00000");
        wait_tx("spi_tmo", 3, ST + 100, el);
        spi_hang = 1'b0;
        chk_str("spi_tmo_resp", tx_str(), eresp);
        chk_val("spi_tmo_starts", 64'(start_cnt - st_base), 64'h1);
        chk_val("spi_tmo_not_early", 64'(el >= int'(ST)), 64'h1);

        // RX stall mid-frame
        mark();
        send_str("{W:1");
        wait_tx("byte_tmo", 3, BT + 100, el);
        chk_str("byte_tmo_resp", tx_str(), eresp);
        chk_val("byte_tmo_starts", 64'(start_cnt - st_base), 64'h0);
        chk_val("byte_tmo_not_early", 64'(el >= int'(BT)), 64'h1);

        // A gap just under the byte timeout keeps the frame alive
        mark();
        send_str("{W:1");
        repeat (BT - 20) @(negedge clk);
        send_str("23:00000");
        wait_tx("byte_alive", 3, 100, el);
        chk_str("byte_alive_resp", tx_str(), kresp);
        chk_val("byte_alive_addr", 64'(last_addr), 64'h123);

        // TX backpressure: hold ready low for 50 cycles
        mark();
        tx_ready = 1'b0;
        send_str("{W:002:00003");
        el = 0;
        while (!tx_valid && el < 100) begin
            @(negedge clk);
            el++;
        end
        chk_val("bp_valid_seen", 64'(tx_valid), 64'h1);
        repeat (50) @(negedge clk);
        chk_val("bp_no_transfer", 64'(txq.size() - tx_base), 64'h0);
        chk_val("bp_data_held", 64'(tx_data), 64'h4B);
        tx_ready = 1'b1;
        wait_tx("bp", 3, 100, el);
        chk_str("bp_resp", tx_str(), kresp);
        chk_val("bp_stable", 64'(stab_err), 64'h0);

        // Reset while waiting on the SPI master
        mark();
        spi_hang = 1'b1;
        send_str("{R:020:00000");
        el = 0;
        while (start_cnt == st_base && el < 100) begin
            @(negedge clk);
            el++;
        end
        chk_val("rst_start_seen", 64'(start_cnt - st_base), 64'h1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_val("rst_mid_outputs",
                {20'h0, tx_valid, spi_start, spi_rw, busy, tx_data, spi_addr, spi_wdata},
                64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (ST + 50) @(negedge clk);
        chk_val("rst_no_tx", 64'(txq.size() - tx_base), 64'h0);
        chk_val("rst_idle", 64'(busy), 64'h0);
        spi_hang = 1'b0;

        // Recovery after reset
        mark();
        spi_rval = 20'hC0FFE;
        send_str("{R:7E7:00000");
        wait_tx("rst_recover", 7, 200, el);
        chk_str("rst_recover_resp", tx_str(), "C0FFE\015\012");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
